// File: rtl/parity_frame_gen.sv
// Streaming lane-parity generator/checker with running frame parity, behind a
// single-stage valid/ready register slice.
module parity_frame_gen #(
  parameter  int DATA_W    = 16,
  parameter  int LANE_W    = 8,
  parameter  int ERR_CNT_W = 8,
  localparam int NLANES    = DATA_W / LANE_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 odd_mode,
  input  logic                 check_en,
  input  logic                 clr_err,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_W-1:0]    s_data,
  input  logic [NLANES-1:0]    s_par,
  input  logic                 s_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_W-1:0]    m_data,
  output logic [NLANES-1:0]    m_par,
  output logic [NLANES-1:0]    m_err,
  output logic                 m_last,
  output logic                 m_frame_par,
  output logic                 frame_active,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] IN_FRAME = 1'b1;

  logic [0:0]        state;
  logic              mode_lat;
  logic              acc;
  logic              accept;
  logic              mode_eff;
  logic              word_par;
  logic [NLANES-1:0] lane_par;
  logic [NLANES-1:0] lane_err;

  // No skid buffer: a new word is taken only if the slice is empty or draining.
  assign s_ready  = !m_valid || m_ready;
  assign accept   = s_valid && s_ready;
  assign mode_eff = (state == IDLE) ? odd_mode : mode_lat;
  assign word_par = ^s_data;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    lane_par = '0;
    for (int k = 0; k < NLANES; k++) begin
      lane_par[k] = (^s_data[k*LANE_W +: LANE_W]) ^ mode_eff;
    end
  end

  assign lane_err     = check_en ? (s_par ^ lane_par) : '0;
  assign frame_active = (state == IN_FRAME);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_par       <= '0;
      m_err       <= '0;
      m_last      <= 1'b0;
      m_frame_par <= 1'b0;
    end else if (accept) begin
      m_valid     <= 1'b1;
      m_data      <= s_data;
      m_par       <= lane_par;
      m_err       <= lane_err;
      m_last      <= s_last;
      m_frame_par <= s_last ? (acc ^ word_par ^ mode_eff) : 1'b0;
    end else if (m_ready) begin
      // Payload is left as-is once drained; only m_valid qualifies it.
      m_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mode_lat <= 1'b0;
      acc      <= 1'b0;
    end else if (accept) begin
      acc <= s_last ? 1'b0 : (acc ^ word_par);
      case (state)
        IDLE: begin
          if (!s_last) begin
            state    <= IN_FRAME;
            mode_lat <= odd_mode;
          end
        end
        IN_FRAME: begin
          if (s_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Counts at acceptance; clear wins over a coincident error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (clr_err) begin
      err_count <= '0;
    end else if (accept && (|lane_err) && !(&err_count)) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_parity_frame_gen.sv
// Self-checking bench for parity_frame_gen: directed table, multi-cycle corner
// sequences and randomized traffic against a frame-level scoreboard model.
module tb_parity_frame_gen;

  localparam int DATA_W    = 16;
  localparam int LANE_W    = 8;
  localparam int ERR_CNT_W = 8;
  localparam int NLANES    = DATA_W / LANE_W;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 odd_mode, check_en, clr_err;
  logic                 s_valid, s_ready, s_last;
  logic [DATA_W-1:0]    s_data;
  logic [NLANES-1:0]    s_par;
  logic                 m_valid, m_ready, m_last, m_frame_par, frame_active;
  logic [DATA_W-1:0]    m_data;
  logic [NLANES-1:0]    m_par, m_err;
  logic [ERR_CNT_W-1:0] err_count;

  parity_frame_gen #(.DATA_W(DATA_W), .LANE_W(LANE_W), .ERR_CNT_W(ERR_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .odd_mode(odd_mode), .check_en(check_en),
    .clr_err(clr_err), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_par(s_par), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_par(m_par), .m_err(m_err), .m_last(m_last),
    .m_frame_par(m_frame_par), .frame_active(frame_active), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [NLANES-1:0] spar;
    logic              last;
    logic              odd;
    logic              chk;
    logic              clr;
    logic              mready;
  } in_t;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [NLANES-1:0] par;
    logic [NLANES-1:0] err;
    logic              last;
    logic              fpar;
  } exp_t;

  typedef struct {
    in_t               in;
    logic [NLANES-1:0] par;
    logic [NLANES-1:0] err;
    logic              fpar;
  } vec_t;

  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state: frame bookkeeping by bit counting.
  exp_t q[$];
  bit   md_in_frame   = 1'b0;
  bit   md_frame_mode = 1'b0;
  int   md_frame_ones = 0;
  int   md_errcnt     = 0;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic in_t mk(input logic v, input logic [DATA_W-1:0] d,
                             input logic [NLANES-1:0] sp, input logic l,
                             input logic o, input logic c, input logic cl,
                             input logic mr);
    in_t r;
    r.valid = v; r.data = d; r.spar = sp; r.last = l;
    r.odd = o; r.chk = c; r.clr = cl; r.mready = mr;
    return r;
  endfunction

  task automatic model_accept(input in_t v);
    exp_t e;
    logic mode;
    logic [LANE_W-1:0] lane;
    mode = md_in_frame ? md_frame_mode : v.odd;
    for (int k = 0; k < NLANES; k++) begin
      lane = v.data[k*LANE_W +: LANE_W];
      e.par[k] = logic'($countones(lane) % 2) ^ mode;
    end
    e.err  = v.chk ? (v.spar ^ e.par) : '0;
    e.data = v.data;
    e.last = v.last;
    md_frame_ones += $countones(v.data);
    if (v.last) begin
      e.fpar = logic'(md_frame_ones % 2) ^ mode;
      md_frame_ones = 0;
      md_in_frame = 1'b0;
    end else begin
      e.fpar = 1'b0;
      if (!md_in_frame) begin
        md_in_frame   = 1'b1;
        md_frame_mode = v.odd;
      end
    end
    q.push_back(e);
    if (!v.clr && e.err != '0 && md_errcnt < (1 << ERR_CNT_W) - 1) md_errcnt++;
  endtask

  // One clock cycle: check registered state, drive, check handshake/payload,
  // advance the model, then let the rising edge happen.
  task automatic cycle(input in_t v);
    logic exp_ready;
    @(negedge clk);
    check("err_count", 32'(err_count), 32'(md_errcnt));
    check("frame_active", 32'(frame_active), 32'(md_in_frame));
    s_valid = v.valid; s_data = v.data; s_par = v.spar; s_last = v.last;
    odd_mode = v.odd; check_en = v.chk; clr_err = v.clr; m_ready = v.mready;
    #1;
    exp_ready = (q.size() == 0) || v.mready;
    check("s_ready", 32'(s_ready), 32'(exp_ready));
    check("m_valid", 32'(m_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("m_data", 32'(m_data), 32'(q[0].data));
      check("m_par", 32'(m_par), 32'(q[0].par));
      check("m_err", 32'(m_err), 32'(q[0].err));
      check("m_last", 32'(m_last), 32'(q[0].last));
      check("m_frame_par", 32'(m_frame_par), 32'(q[0].fpar));
      if (v.mready) void'(q.pop_front());
    end
    if (v.clr) md_errcnt = 0;
    if (v.valid && exp_ready) model_accept(v);
    @(posedge clk);
  endtask

  task automatic check_reset_outputs();
    check("rst m_valid", 32'(m_valid), 32'd0);
    check("rst m_data", 32'(m_data), 32'd0);
    check("rst m_par", 32'(m_par), 32'd0);
    check("rst m_err", 32'(m_err), 32'd0);
    check("rst m_last", 32'(m_last), 32'd0);
    check("rst m_frame_par", 32'(m_frame_par), 32'd0);
    check("rst frame_active", 32'(frame_active), 32'd0);
    check("rst err_count", 32'(err_count), 32'd0);
    check("rst s_ready", 32'(s_ready), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    s_valid = 1'b0;
    #1;
    check_reset_outputs();
    q.delete();
    md_in_frame = 1'b0;
    md_frame_ones = 0;
    md_errcnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_vec(input int i, input in_t v, input logic [NLANES-1:0] par,
                         input logic [NLANES-1:0] err, input logic fpar);
    tbl[i].in = v; tbl[i].par = par; tbl[i].err = err; tbl[i].fpar = fpar;
  endtask

  initial begin
    rst_n = 1'b0;
    s_valid = 1'b0; s_data = '0; s_par = '0; s_last = 1'b0;
    odd_mode = 1'b0; check_en = 1'b0; clr_err = 1'b0; m_ready = 1'b1;

    // Single-word frames: inputs and hand-computed outputs.
    set_vec(0, mk(1, 16'h8001, 2'b00, 1, 0, 0, 0, 1), 2'b11, 2'b00, 1'b0);
    set_vec(1, mk(1, 16'h0000, 2'b00, 1, 1, 0, 0, 1), 2'b11, 2'b00, 1'b1);
    set_vec(2, mk(1, 16'h0101, 2'b10, 1, 0, 1, 0, 1), 2'b11, 2'b01, 1'b0);
    set_vec(3, mk(1, 16'hFFFF, 2'b00, 1, 1, 0, 0, 1), 2'b11, 2'b00, 1'b1);
    set_vec(4, mk(1, 16'h00FF, 2'b11, 1, 0, 0, 0, 1), 2'b00, 2'b00, 1'b0);
    set_vec(5, mk(1, 16'h0100, 2'b01, 1, 0, 1, 0, 1), 2'b10, 2'b11, 1'b1);
    set_vec(6, mk(1, 16'h7F00, 2'b00, 1, 1, 1, 0, 1), 2'b01, 2'b01, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      cycle(tbl[i].in);
      #1;
      check($sformatf("tbl%0d m_valid", i), 32'(m_valid), 32'd1);
      check($sformatf("tbl%0d m_par", i), 32'(m_par), 32'(tbl[i].par));
      check($sformatf("tbl%0d m_err", i), 32'(m_err), 32'(tbl[i].err));
      check($sformatf("tbl%0d m_frame_par", i), 32'(m_frame_par), 32'(tbl[i].fpar));
      check($sformatf("tbl%0d m_last", i), 32'(m_last), 32'd1);
      check($sformatf("tbl%0d frame_active", i), 32'(frame_active), 32'd0);
    end

    // Even frame 1,3,7; odd_mode raised mid-frame must be ignored.
    cycle(mk(1, 16'h0001, 2'b00, 0, 0, 0, 0, 1));
    #1;
    check("frm w1 m_par", 32'(m_par), 32'h1);
    check("frm w1 active", 32'(frame_active), 32'd1);
    cycle(mk(1, 16'h0003, 2'b00, 0, 1, 0, 0, 1));
    #1;
    check("frm w2 m_par", 32'(m_par), 32'h0);
    check("frm w2 active", 32'(frame_active), 32'd1);
    cycle(mk(1, 16'h0007, 2'b00, 1, 1, 0, 0, 1));
    #1;
    check("frm w3 m_par", 32'(m_par), 32'h1);
    check("frm w3 m_frame_par", 32'(m_frame_par), 32'd0);
    check("frm w3 m_last", 32'(m_last), 32'd1);
    check("frm w3 active", 32'(frame_active), 32'd0);

    // Backpressure: s_valid held while m_ready=0 for 3 cycles.
    cycle(mk(1, 16'h1234, 2'b00, 1, 0, 0, 0, 1));
    for (int i = 0; i < 3; i++) begin
      cycle(mk(1, 16'hA5A5 + 16'(i), 2'b00, 1, 0, 0, 0, 0));
      #1;
      check("bp s_ready", 32'(s_ready), 32'd0);
      check("bp m_data held", 32'(m_data), 32'h1234);
    end
    cycle(mk(1, 16'h5678, 2'b00, 1, 0, 0, 0, 1));
    cycle(mk(0, 16'h0000, 2'b00, 0, 0, 0, 0, 1));

    // Error counter saturation and clear priority.
    for (int i = 0; i < 300; i++) cycle(mk(1, 16'h0101, 2'b10, 1, 0, 1, 0, 1));
    #1;
    check("err_count saturated", 32'(err_count), 32'd255);
    cycle(mk(1, 16'h0101, 2'b10, 1, 0, 1, 1, 1));
    #1;
    check("err_count clr priority", 32'(err_count), 32'd0);

    // Reset after 2 of 4 words; the truncated frame must leave no trace.
    cycle(mk(1, 16'h00F0, 2'b00, 0, 1, 0, 0, 1));
    cycle(mk(1, 16'h0F01, 2'b00, 0, 1, 0, 0, 1));
    do_reset();
    cycle(mk(1, 16'h0001, 2'b00, 1, 0, 0, 0, 1));
    #1;
    check("post-rst m_frame_par", 32'(m_frame_par), 32'd1);
    check("post-rst m_par", 32'(m_par), 32'h1);

    // Randomized traffic against the scoreboard.
    for (int i = 0; i < 3000; i++) begin
      cycle(mk(logic'($urandom_range(0, 3) != 0), 16'($urandom),
               2'($urandom), logic'($urandom_range(0, 3) == 0),
               logic'($urandom), logic'($urandom), logic'($urandom_range(0, 63) == 0),
               logic'($urandom_range(0, 3) != 0)));
    end
    cycle(mk(0, 16'h0000, 2'b00, 0, 0, 0, 0, 1));
    cycle(mk(0, 16'h0000, 2'b00, 0, 0, 0, 0, 1));
    check("scoreboard drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/parity_frame_gen.md
# parity_frame_gen

Streaming, parametrised parity generator and checker. It accepts DATA_W-bit words on a valid/ready input and returns them registered on a valid/ready output. Each output word carries per-lane parity, a per-lane mismatch flag (check mode), and a running frame parity that is valid on the frame's last word. The block sits between a word source and a serial/link framer and replaces the fixed 8-bit combinational even-parity generator.

## Interface
- DATA_W, 16: data width; must be a multiple of LANE_W.
- LANE_W, 8: bits per parity lane; NLANES = DATA_W/LANE_W (derived).
- ERR_CNT_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- odd_mode  in  1  0 = even parity, 1 = odd parity; latched at frame start.
- check_en  in  1  1 = compare s_par against computed lane parity.
- clr_err  in  1  synchronous clear of err_count.
- s_valid  in  1  input word valid.
- s_ready  out  1  block can accept a word.
- s_data  in  DATA_W  input word.
- s_par  in  NLANES  received lane parity; used only when check_en=1.
- s_last  in  1  marks the last word of a frame.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts the output word.
- m_data  out  DATA_W  registered copy of s_data.
- m_par  out  NLANES  computed lane parity; bit k covers s_data[k*LANE_W +: LANE_W].
- m_err  out  NLANES  per-lane mismatch; all zero when check_en was 0 at acceptance.
- m_last  out  1  registered s_last.
- m_frame_par  out  1  parity over all bits of the frame; meaningful only when m_last=1, otherwise 0.
- frame_active  out  1  1 while in state IN_FRAME.
- err_count  out  ERR_CNT_W  count of accepted words with any m_err bit set.

## Operation
- Accept: an input word is accepted when s_valid && s_ready. Output transfer: m_valid && m_ready.
- s_ready = !m_valid || m_ready. This is a single-stage register slice with no skid buffer.
- Lane parity: m_par[k] = ^lane_k XOR mode_eff.
- mode_eff is odd_mode when state=IDLE. In IN_FRAME it is the mode latched at the first word of the frame.
- odd_mode changes mid-frame are ignored until the frame ends.
- Check: m_err[k] = check_en && (s_par[k] != computed m_par[k]). check_en is sampled at acceptance.
- Frame accumulator acc is the running XOR of every data bit of accepted words in the current frame.
  - On an accepted last word: m_frame_par = acc ^ (^s_data) ^ mode_eff, and acc clears to 0.
- FSM:
  - IDLE, accept with s_last=0: go to IN_FRAME and latch odd_mode.
  - IDLE, accept with s_last=1: single-word frame; stay in IDLE.
  - IN_FRAME, accept with s_last=1: go to IDLE.
  - Otherwise hold state.
- err_count increments by 1 per accepted word with |m_err (computed at acceptance, not at output transfer).
  - Saturates at 2^ERR_CNT_W-1.
  - clr_err has priority: if clr_err and an error occur in the same cycle, the result is 0.

## Timing
- Latency: one cycle from acceptance to m_valid.
- Full throughput (one word per cycle) when m_ready=1.
- Backpressure: while m_valid=1 and m_ready=0, all m_* outputs hold stable and s_ready=0.
- Simultaneous output transfer and new acceptance in one cycle: the output register reloads and m_valid stays 1.
- Reset (rst_n=0, asynchronous, any time including mid-frame) forces:
  - m_valid=0, m_data=0, m_par=0, m_err=0, m_last=0, m_frame_par=0
  - frame_active=0, err_count=0, acc=0, state=IDLE
- s_ready is 1 during and after reset, since m_valid=0. The first cycle after rst_n rises can accept a word.
- A frame truncated by reset is discarded. The next accepted word starts a new frame.
- s_par is ignored when check_en=0. s_last on an unaccepted cycle has no effect.

## Test plan
Defaults DATA_W=16, LANE_W=8.
- Even mode, s_data=0x8001, s_last=1, m_ready=1 → next cycle: m_valid=1, m_par=2'b11, m_frame_par=0, m_last=1, frame_active stays 0.
- Odd mode, s_data=0x0000, s_last=1 → m_par=2'b11, m_frame_par=1.
- Even-mode frame 0x0001, 0x0003, 0x0007 (last on the third); odd_mode set to 1 after the first word:
  - m_par = 2'b01, 2'b00, 2'b01.
  - m_frame_par=0 (6 set bits).
  - frame_active=1 during words 2–3.
  - The mode change is ignored.
- Backpressure: s_valid held high, m_ready=0 for 3 cycles → s_ready=0 and m_* stable throughout; each word delivered exactly once, in order.
- Check mode, even, s_data=0x0101, s_par=2'b10 → m_err=2'b01, err_count=1.
  - Force 300 errors → err_count=255.
  - Error with clr_err in the same cycle → 0.
- Reset mid-frame after 2 of 4 words → all outputs at reset values.
  - A following single-word frame 0x0001 in even mode → m_frame_par=1, unaffected by the discarded words.
